// File: rtl/iq_boxcar_decim.sv
// iq_boxcar_decim: boxcar-average decimator for an I/Q sample stream.
//   Pulls samples from an upstream FIFO, sums N = 2^DecRatio of them per
//   block and emits the floor average on a PushOut/StopIn handshake.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   fifo_samp         head-of-FIFO sample {I, Q}, valid when !fifo_empty
//   fifo_empty        upstream FIFO is empty
//   fifo_PullOut      head sample consumed this cycle
//   DecRatio          log2 of the decimation factor (latched per block)
//   StopIn            downstream back-pressure
//   PushOut           DoutI/DoutQ valid
//   DoutI, DoutQ      averaged I/Q result

package iq_boxcar_decim_pkg;
  localparam int SAMP_W = 24;
  typedef struct packed {
    logic signed [SAMP_W-1:0] I;
    logic signed [SAMP_W-1:0] Q;
  } Samp;
endpackage

module iq_boxcar_decim
  import iq_boxcar_decim_pkg::*;
#(
  // The Samp fields are SAMP_W bits; W is expected to match.
  parameter int W    = SAMP_W,
  parameter int ACCW = W + 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  Samp                 fifo_samp,
  input  logic                fifo_empty,
  output logic                fifo_PullOut,
  input  logic [1:0]          DecRatio,
  input  logic                StopIn,
  output logic                PushOut,
  output logic signed [W-1:0] DoutI,
  output logic signed [W-1:0] DoutQ
);

  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             cnt;
  logic [2:0]             cnt_max;
  logic [1:0]             ratio_q;
  logic [1:0]             ratio_eff;
  logic signed [ACCW-1:0] acc_i, acc_q;
  logic signed [ACCW-1:0] sum_i, sum_q;
  logic                   last;

  // A held output blocks intake so the result cannot be overwritten.
  assign fifo_PullOut = !Reset && !fifo_empty && !(PushOut && StopIn);

  // The first sample of a block sees the live ratio; later ones the latched.
  assign ratio_eff = (cnt == 3'd0) ? DecRatio : ratio_q;

  always_comb begin
    cnt_max = 3'd0;
    case (ratio_eff)
      2'd0: cnt_max = 3'd0;
      2'd1: cnt_max = 3'd1;
      2'd2: cnt_max = 3'd3;
      2'd3: cnt_max = 3'd7;
      default: cnt_max = 3'd0;
    endcase
  end

  assign last  = fifo_PullOut && (cnt == cnt_max);
  assign sum_i = acc_i + ACCW'(fifo_samp.I);
  assign sum_q = acc_q + ACCW'(fifo_samp.Q);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  // Next state: a completing block always lands in OUT, even from OUT,
  // which is what lets N=1 stream back-to-back.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last) state_nxt = OUT;
      OUT:     if (last) state_nxt = OUT;
               else if (!StopIn) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Output decode
  always_comb begin
    PushOut = (state == OUT);
  end

  // Accumulate / emit datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_i   <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      ratio_q <= '0;
      DoutI   <= '0;
      DoutQ   <= '0;
    end else if (fifo_PullOut) begin
      if (cnt == 3'd0) ratio_q <= DecRatio;
      if (last) begin
        // Arithmetic shift gives floor division; then drop the guard bits.
        DoutI <= W'(sum_i >>> ratio_eff);
        DoutQ <= W'(sum_q >>> ratio_eff);
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_iq_boxcar_decim.sv
// Self-checking bench for iq_boxcar_decim: a sample-list reference model
// checked every cycle, plus literal expectations for the directed cases.
module tb_iq_boxcar_decim;
  import iq_boxcar_decim_pkg::*;

  localparam int W = 24;

  typedef struct {
    int i;
    int q;
  } smp_t;

  logic                Clk = 1'b0;
  logic                Reset;
  Samp                 fifo_samp;
  logic                fifo_empty;
  logic                fifo_PullOut;
  logic [1:0]          DecRatio;
  logic                StopIn;
  logic                PushOut;
  logic signed [W-1:0] DoutI, DoutQ;

  iq_boxcar_decim #(.W(W)) dut (
    .Clk(Clk), .Reset(Reset), .fifo_samp(fifo_samp), .fifo_empty(fifo_empty),
    .fifo_PullOut(fifo_PullOut), .DecRatio(DecRatio), .StopIn(StopIn),
    .PushOut(PushOut), .DoutI(DoutI), .DoutQ(DoutQ)
  );

  always #5 Clk = ~Clk;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   gap_en = 0;
  smp_t src[$];      // samples still to be offered
  smp_t blk[$];      // samples in the current model block
  smp_t outlog[$];   // results handed downstream
  smp_t ref_log[$];
  bit   m_push = 0;
  int   m_di = 0, m_dq = 0;
  int   m_ratio = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: collect each block's samples, average with floor division.
  task automatic model();
    bit pull;
    bit done;
    longint si, sq;
    pull = !Reset && !fifo_empty && !(m_push && StopIn);
    if (Reset) begin
      blk.delete();
      m_push = 0; m_di = 0; m_dq = 0; m_ratio = 0;
      return;
    end
    if (m_push && !StopIn) outlog.push_back('{m_di, m_dq});
    done = 0;
    if (pull) begin
      if (blk.size() == 0) m_ratio = int'(DecRatio);
      blk.push_back('{int'($signed(fifo_samp.I)), int'($signed(fifo_samp.Q))});
      void'(src.pop_front());
      if (blk.size() == (1 << m_ratio)) begin
        si = 0; sq = 0;
        foreach (blk[k]) begin si += blk[k].i; sq += blk[k].q; end
        m_di = int'(si >>> m_ratio);
        m_dq = int'(sq >>> m_ratio);
        blk.delete();
        done = 1;
      end
    end
    m_push = done || (m_push && StopIn);
  endtask

  task automatic drive();
    fifo_empty = (src.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
    if (src.size() != 0) begin
      fifo_samp.I = W'(src[0].i);
      fifo_samp.Q = W'(src[0].q);
    end else begin
      fifo_samp = '0;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model();
    #1;
    drive();
  endtask

  task automatic run(string name, int max);
    int k = 0;
    while ((src.size() != 0 || m_push) && k < max) begin
      step();
      k++;
    end
    chk({name, "_timeout"}, k < max, 1);
    step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    drive();
  endtask

  // Cycle-by-cycle compare against the model.
  initial forever begin
    @(negedge Clk);
    chk("pullout", fifo_PullOut, !Reset && !fifo_empty && !(m_push && StopIn));
    chk("pushout", PushOut, m_push);
    if (m_push) begin
      chk("douti", longint'(DoutI), m_di);
      chk("doutq", longint'(DoutQ), m_dq);
    end
  end

  initial begin
    Reset = 1'b1; StopIn = 1'b0; DecRatio = 2'd0; fifo_empty = 1'b1; fifo_samp = '0;
    step(); step(); step();
    #1;
    chk("rst_push", PushOut, 0);
    chk("rst_douti", longint'(DoutI), 0);
    chk("rst_doutq", longint'(DoutQ), 0);
    Reset = 1'b0;

    // N=4 basic average, one pulse one cycle after the 4th accept
    DecRatio = 2'd2; outlog.delete();
    src = '{'{4, -4}, '{8, -8}, '{12, -12}, '{16, -16}};
    drive();
    run("n4", 50);
    chk("n4_cnt", outlog.size(), 1);
    chk("n4_i", outlog[0].i, 10);
    chk("n4_q", outlog[0].q, -10);

    // N=2 floor on negatives
    DecRatio = 2'd1; outlog.delete();
    src = '{'{1, -1}, '{2, -2}};
    drive();
    run("n2", 50);
    chk("n2_i", outlog[0].i, 1);
    chk("n2_q", outlog[0].q, -2);

    // N=8 full scale
    DecRatio = 2'd3; outlog.delete();
    repeat (8) src.push_back('{8388607, -8388608});
    drive();
    run("n8", 80);
    chk("n8_i", outlog[0].i, 8388607);
    chk("n8_q", outlog[0].q, -8388608);

    // N=1 with a 3-cycle hold during PushOut
    begin
      int k = 0;
      DecRatio = 2'd0; outlog.delete();
      src = '{'{5, -5}, '{6, -6}, '{7, -7}, '{8, -8}};
      drive();
      while (!m_push && k < 20) begin step(); k++; end
      chk("hold_wait", k < 20, 1);
      StopIn = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (c != 0) step();
        #1;
        chk("hold_pull", fifo_PullOut, 0);
        chk("hold_push", PushOut, 1);
        chk("hold_i", longint'(DoutI), 5);
      end
      StopIn = 1'b0;
      run("n1", 50);
      chk("n1_cnt", outlog.size(), 4);
      for (int j = 0; j < 4 && j < outlog.size(); j++) begin
        chk("n1_i", outlog[j].i, 5 + j);
        chk("n1_q", outlog[j].q, -5 - j);
      end
    end

    // Reset discards a partial block
    DecRatio = 2'd2; outlog.delete();
    src = '{'{100, 100}, '{100, 100}};
    drive();
    run("part", 50);
    do_reset();
    src = '{'{0, 0}, '{0, 0}, '{0, 0}, '{8, -8}};
    drive();
    run("rst_blk", 50);
    chk("rst_blk_cnt", outlog.size(), 1);
    chk("rst_blk_i", outlog[0].i, 2);
    chk("rst_blk_q", outlog[0].q, -2);

    // Input gaps must not change results
    outlog.delete();
    src = '{'{3, -3}, '{-7, 7}, '{10, -10}, '{1, -1}, '{-5, 5}, '{2, -2}, '{9, -9}, '{9, -9}};
    drive();
    run("nogap", 80);
    ref_log = outlog;
    chk("nogap_i0", ref_log[0].i, 1);
    chk("nogap_q0", ref_log[0].q, -2);
    chk("nogap_i1", ref_log[1].i, 3);
    chk("nogap_q1", ref_log[1].q, -4);
    do_reset();
    outlog.delete(); gap_en = 1;
    src = '{'{3, -3}, '{-7, 7}, '{10, -10}, '{1, -1}, '{-5, 5}, '{2, -2}, '{9, -9}, '{9, -9}};
    drive();
    run("gap", 300);
    gap_en = 0;
    chk("gap_cnt", outlog.size(), ref_log.size());
    for (int j = 0; j < ref_log.size() && j < outlog.size(); j++) begin
      chk("gap_i", outlog[j].i, ref_log[j].i);
      chk("gap_q", outlog[j].q, ref_log[j].q);
    end

    // Ratio change mid-block is ignored until the next block
    DecRatio = 2'd2; outlog.delete();
    src = '{'{1, -1}, '{2, -2}};
    drive();
    run("chg_a", 50);
    DecRatio = 2'd0;
    src = '{'{3, -3}, '{4, -4}, '{9, -9}};
    drive();
    run("chg_b", 50);
    chk("chg_cnt", outlog.size(), 2);
    chk("chg_i0", outlog[0].i, 2);
    chk("chg_q0", outlog[0].q, -3);
    chk("chg_i1", outlog[1].i, 9);
    chk("chg_q1", outlog[1].q, -9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
